// File: rtl/chip8_stack_pkg.sv
// Shared opcode encoding and default geometry for the CHIP-8 subroutine stack.
package chip8_stack_pkg;

  typedef enum logic [1:0] {
    STK_IDLE    = 2'b00,
    STK_PUSH    = 2'b01,
    STK_POP     = 2'b10,
    STK_REPLACE = 2'b11
  } stk_op_t;

  localparam int unsigned STK_WIDTH = 16;
  localparam int unsigned STK_DEPTH = 16;

endpackage

// File: rtl/chip8_stack_mem.sv
// Stack storage: one synchronous write port, one asynchronous read port, no reset.
module chip8_stack_mem #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AddrW = 4
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/chip8_call_stack.sv
// CHIP-8 call stack: saturating LIFO with replace-top, synchronous clear,
// optional edge-triggered opcodes, occupancy and sticky error flags.
module chip8_call_stack
  import chip8_stack_pkg::*;
#(
  parameter int unsigned WIDTH     = STK_WIDTH,
  parameter int unsigned DEPTH     = STK_DEPTH,
  parameter bit          EDGE_TRIG = 1'b1
) (
  input  logic                       cpu_clk,
  input  logic                       reset_n,
  input  logic [1:0]                 WE,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           writedata,
  output logic [WIDTH-1:0]           outdata,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       done,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned CntW  = $clog2(DEPTH + 1);
  localparam int unsigned AddrW = $clog2(DEPTH);

  logic [CntW-1:0]  sp_q, sp_d, sp_m1;
  logic [1:0]       we_q;
  logic [WIDTH-1:0] outdata_q, outdata_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic             mem_we;
  logic [AddrW-1:0] mem_waddr;
  logic [WIDTH-1:0] mem_rdata;
  logic             is_empty, is_full, issue;
  stk_op_t          op;

  assign op       = stk_op_t'(WE);
  assign sp_m1    = sp_q - CntW'(1);
  assign is_empty = (sp_q == '0);
  assign is_full  = (sp_q == CntW'(DEPTH));
  // In edge mode a held opcode is only issued on the cycle it first appears.
  assign issue    = (op != STK_IDLE) && (!EDGE_TRIG || (WE != we_q));

  chip8_stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AddrW (AddrW)
  ) u_mem (
    .clk_i   (cpu_clk),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (writedata),
    .raddr_i (AddrW'(sp_m1)),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    sp_d      = sp_q;
    outdata_d = outdata_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    done_d    = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = AddrW'(sp_m1);
    if (clear) begin
      sp_d  = '0;
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else if (issue) begin
      case (op)
        STK_PUSH: begin
          if (is_full) begin
            ovf_d = 1'b1;
          end else begin
            mem_we    = 1'b1;
            mem_waddr = AddrW'(sp_q);
            sp_d      = sp_q + CntW'(1);
            done_d    = 1'b1;
          end
        end
        STK_POP: begin
          if (is_empty) begin
            unf_d = 1'b1;
          end else begin
            outdata_d = mem_rdata;
            sp_d      = sp_m1;
            done_d    = 1'b1;
          end
        end
        STK_REPLACE: begin
          if (is_empty) begin
            unf_d = 1'b1;
          end else begin
            outdata_d = mem_rdata;
            mem_we    = 1'b1;
            done_d    = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) begin
      sp_q      <= '0;
      we_q      <= 2'b00;
      outdata_q <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      sp_q      <= sp_d;
      we_q      <= WE;
      outdata_q <= outdata_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  assign outdata   = outdata_q;
  assign top       = is_empty ? '0 : mem_rdata;
  assign count     = sp_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign done      = done_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_chip8_call_stack.sv
// Drives an edge-triggered and a level-triggered stack with shared stimulus and
// compares both against an array-based stack model every cycle.
module tb_chip8_call_stack;

  localparam int unsigned W = 16;
  localparam int unsigned D = 4;

  logic          cpu_clk;
  logic          reset_n;
  logic [1:0]    we;
  logic          clr;
  logic [W-1:0]  wd;

  logic [W-1:0]  e_out, e_top, l_out, l_top;
  logic [2:0]    e_cnt, l_cnt;
  logic          e_empty, e_full, e_done, e_ovf, e_unf;
  logic          l_empty, l_full, l_done, l_ovf, l_unf;

  int n_checks = 0;
  int n_errors = 0;

  // Model state, index 0 = edge-triggered instance, 1 = level-triggered.
  logic [W-1:0] m_data [2][D];
  int           m_cnt  [2];
  logic [W-1:0] m_out  [2];
  bit           m_ovf  [2];
  bit           m_unf  [2];
  bit           m_done [2];
  logic [1:0]   m_prev [2];

  chip8_call_stack #(.WIDTH(W), .DEPTH(D), .EDGE_TRIG(1'b1)) dut_e (
    .cpu_clk   (cpu_clk),
    .reset_n   (reset_n),
    .WE        (we),
    .clear     (clr),
    .writedata (wd),
    .outdata   (e_out),
    .top       (e_top),
    .count     (e_cnt),
    .empty     (e_empty),
    .full      (e_full),
    .done      (e_done),
    .overflow  (e_ovf),
    .underflow (e_unf)
  );

  chip8_call_stack #(.WIDTH(W), .DEPTH(D), .EDGE_TRIG(1'b0)) dut_l (
    .cpu_clk   (cpu_clk),
    .reset_n   (reset_n),
    .WE        (we),
    .clear     (clr),
    .writedata (wd),
    .outdata   (l_out),
    .top       (l_top),
    .count     (l_cnt),
    .empty     (l_empty),
    .full      (l_full),
    .done      (l_done),
    .overflow  (l_ovf),
    .underflow (l_unf)
  );

  initial begin
    cpu_clk = 1'b0;
    forever #5 cpu_clk = ~cpu_clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i]  = 0;
      m_out[i]  = '0;
      m_ovf[i]  = 1'b0;
      m_unf[i]  = 1'b0;
      m_done[i] = 1'b0;
      m_prev[i] = 2'b00;
    end
  endfunction

  // One rising edge of stack behaviour for instance i, from the current inputs.
  function automatic void model_step(int i);
    bit issue;
    bit ok;
    issue = (we != 2'b00) && ((i == 1) || (we != m_prev[i]));
    ok    = 1'b0;
    if (clr) begin
      m_cnt[i] = 0;
      m_ovf[i] = 1'b0;
      m_unf[i] = 1'b0;
    end else if (issue) begin
      if (we == 2'b01) begin
        if (m_cnt[i] == D) m_ovf[i] = 1'b1;
        else begin
          m_data[i][m_cnt[i]] = wd;
          m_cnt[i]++;
          ok = 1'b1;
        end
      end else if (m_cnt[i] == 0) begin
        m_unf[i] = 1'b1;
      end else begin
        m_out[i] = m_data[i][m_cnt[i]-1];
        if (we == 2'b10) m_cnt[i]--;
        else m_data[i][m_cnt[i]-1] = wd;
        ok = 1'b1;
      end
    end
    m_done[i] = ok;
    m_prev[i] = we;
  endfunction

  task automatic check_inst(input int i, input string p, input logic [2:0] cnt,
                            input logic [W-1:0] out, input logic [W-1:0] tp,
                            input logic emp, input logic ful, input logic dn,
                            input logic ovf, input logic unf);
    logic [W-1:0] exp_top;
    exp_top = (m_cnt[i] == 0) ? '0 : m_data[i][m_cnt[i]-1];
    check_eq({p, "count"}, 32'(cnt), 32'(m_cnt[i]));
    check_eq({p, "outdata"}, 32'(out), 32'(m_out[i]));
    check_eq({p, "top"}, 32'(tp), 32'(exp_top));
    check_eq({p, "empty"}, 32'(emp), 32'(m_cnt[i] == 0));
    check_eq({p, "full"}, 32'(ful), 32'(m_cnt[i] == D));
    check_eq({p, "done"}, 32'(dn), 32'(m_done[i]));
    check_eq({p, "overflow"}, 32'(ovf), 32'(m_ovf[i]));
    check_eq({p, "underflow"}, 32'(unf), 32'(m_unf[i]));
  endtask

  task automatic check_all();
    check_inst(0, "edge_", e_cnt, e_out, e_top, e_empty, e_full, e_done, e_ovf, e_unf);
    check_inst(1, "level_", l_cnt, l_out, l_top, l_empty, l_full, l_done, l_ovf, l_unf);
  endtask

  // Apply inputs, take one rising edge, then compare 1 time unit later.
  task automatic tick(input logic [1:0] w, input logic c, input logic [W-1:0] d);
    we  = w;
    clr = c;
    wd  = d;
    @(posedge cpu_clk);
    model_step(0);
    model_step(1);
    #1;
    check_all();
  endtask

  // Called at posedge+1; asserts reset between edges and verifies it acts at once.
  task automatic async_reset();
    #3;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all();
    #3;
    reset_n = 1'b1;
  endtask

  task automatic push_held(input logic [W-1:0] d);
    tick(2'b01, 1'b0, d);
    tick(2'b01, 1'b0, d);
    tick(2'b00, 1'b0, '0);
    tick(2'b00, 1'b0, '0);
  endtask

  initial begin
    reset_n = 1'b0;
    we      = 2'b00;
    clr     = 1'b0;
    wd      = '0;
    model_reset();
    #12;
    check_all();
    #5;
    reset_n = 1'b1;
    repeat (4) tick(2'b00, 1'b0, '0);

    push_held(16'hF000);
    push_held(16'h0F00);
    push_held(16'h00F0);
    push_held(16'h000F);
    repeat (2) begin
      tick(2'b10, 1'b0, '0);
      tick(2'b00, 1'b0, '0);
    end

    tick(2'b11, 1'b0, 16'h8888);
    tick(2'b00, 1'b0, '0);
    repeat (3) begin
      tick(2'b10, 1'b0, '0);
      tick(2'b00, 1'b0, '0);
    end

    tick(2'b00, 1'b1, '0);
    for (int k = 0; k < 5; k++) begin
      tick(2'b01, 1'b0, 16'h1111 * (k + 1));
      tick(2'b00, 1'b0, '0);
    end
    tick(2'b10, 1'b0, '0);
    tick(2'b00, 1'b0, '0);
    tick(2'b00, 1'b1, '0);

    tick(2'b10, 1'b0, '0);
    tick(2'b00, 1'b0, '0);
    tick(2'b01, 1'b1, 16'h1234);
    tick(2'b00, 1'b0, '0);

    // Direct 01 -> 10 change issues a pop with no idle cycle in between.
    tick(2'b01, 1'b0, 16'h5A5A);
    tick(2'b10, 1'b0, '0);
    tick(2'b00, 1'b1, '0);

    repeat (3) tick(2'b01, 1'b0, 16'hABCD);
    async_reset();
    tick(2'b01, 1'b0, 16'hABCD);
    tick(2'b01, 1'b0, 16'hABCD);
    tick(2'b00, 1'b0, '0);

    for (int k = 0; k < 400; k++) begin
      tick(2'($urandom_range(3, 0)), ($urandom_range(15, 0) == 0), W'($urandom));
      if ($urandom_range(99, 0) == 0) async_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
